// File: rtl/insn_fifo.sv
// insn_fifo: instruction FIFO between fetch and decode/dispatch.
//   Holds {pc, insn} entries in program order. The head entry is always
//   visible on o_fifo_data (first-word-fall-through). Fetch is backpressured
//   through o_fifo_full, and a redirect (i_flush) discards all contents.
//
// Ports:
//   clk           core clock; all state updates on posedge
//   n_rst         asynchronous active-low reset
//   i_flush       synchronous redirect/flush; empties the FIFO
//   i_fifo_data   entry written by fetch
//   i_fifo_wr_en  write request from fetch
//   o_fifo_full   FIFO holds FIFO_DEPTH entries
//   o_fifo_data   head entry (valid only while o_fifo_valid)
//   o_fifo_valid  FIFO non-empty
//   i_fifo_rd_en  decode pops the head this cycle
//   o_fifo_count  current occupancy
//
// FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module insn_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          i_flush,
  input  logic [DATA_WIDTH-1:0]         i_fifo_data,
  input  logic                          i_fifo_wr_en,
  output logic                          o_fifo_full,
  output logic [DATA_WIDTH-1:0]         o_fifo_data,
  output logic                          o_fifo_valid,
  input  logic                          i_fifo_rd_en,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  rd_fire, wr_fire;

  assign o_fifo_valid = (count != '0);
  assign o_fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign o_fifo_data  = mem[rd_ptr];
  assign o_fifo_count = count;

  // A pop while empty is ignored; a write while full only lands if the
  // head is leaving in the same cycle.
  assign rd_fire = i_fifo_rd_en & o_fifo_valid;
  assign wr_fire = i_fifo_wr_en & (~o_fifo_full | rd_fire);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      // Flush wins over any same-cycle read/write.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(wr_fire) - CNT_W'(rd_fire);
    end
  end

  // Storage is not reset; contents are only observable behind valid.
  always_ff @(posedge clk) begin
    if (wr_fire && !i_flush) mem[wr_ptr] <= i_fifo_data;
  end

endmodule

// File: tb/tb_insn_fifo.sv
module tb_insn_fifo;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        i_flush;
  logic [63:0] i_fifo_data;
  logic        i_fifo_wr_en;
  logic        o_fifo_full;
  logic [63:0] o_fifo_data;
  logic        o_fifo_valid;
  logic        i_fifo_rd_en;
  logic [3:0]  o_fifo_count;

  int vectors = 0;
  int miscompares = 0;

  insn_fifo #(.DATA_WIDTH(64), .FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .i_flush      (i_flush),
    .i_fifo_data  (i_fifo_data),
    .i_fifo_wr_en (i_fifo_wr_en),
    .o_fifo_full  (o_fifo_full),
    .o_fifo_data  (o_fifo_data),
    .o_fifo_valid (o_fifo_valid),
    .i_fifo_rd_en (i_fifo_rd_en),
    .o_fifo_count (o_fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ent(input int pc, input int insn);
    logic [31:0] p, n;
    p = pc;
    n = insn;
    return {p, n};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 1 time unit after a posedge; outputs sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [63:0] d, input logic rd, input logic fl);
    i_fifo_wr_en = wr;
    i_fifo_data  = d;
    i_fifo_rd_en = rd;
    i_flush      = fl;
  endtask

  initial begin
    logic [63:0] q[$];
    int wi, ri;
    logic wr, rd, wf, rf;

    n_rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("rst_valid", o_fifo_valid, 0);
    chk("rst_full",  o_fifo_full, 0);
    chk("rst_count", o_fifo_count, 0);
    #1 n_rst = 1'b1;
    step();

    // Asynchronous reset mid-cycle with three entries held.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, ent(4*k, 'h13+k), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("pre_rst_count", o_fifo_count, 3);
    #2 n_rst = 1'b0;
    #1;
    chk("async_rst_valid", o_fifo_valid, 0);
    chk("async_rst_full",  o_fifo_full, 0);
    chk("async_rst_count", o_fifo_count, 0);
    n_rst = 1'b1;
    step();
    chk("post_rst_count", o_fifo_count, 0);

    // Fill to full; first write is visible one cycle later (FWFT).
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, ent(4*k, 'h13+k), 1'b0, 1'b0);
      step();
      if (k == 0) begin
        chk("fwft_valid", o_fifo_valid, 1);
        chk("fwft_data",  o_fifo_data, ent(0, 'h13));
      end
    end
    chk("fill_full",  o_fifo_full, 1);
    chk("fill_count", o_fifo_count, 8);
    drive(1'b1, 64'hDEAD, 1'b0, 1'b0);
    step();
    chk("drop_count", o_fifo_count, 8);
    chk("drop_full",  o_fifo_full, 1);
    for (int k = 0; k < 8; k++) begin
      chk("drain_data", o_fifo_data, ent(4*k, 'h13+k));
      drive(1'b0, '0, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("drain_valid", o_fifo_valid, 0);
    chk("drain_count", o_fifo_count, 0);

    // Full with concurrent read and write.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, ent(4*k, 'h13+k), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, ent('h100, 'h99), 1'b1, 1'b0);
    step();
    chk("fullrw_count", o_fifo_count, 8);
    chk("fullrw_full",  o_fifo_full, 1);
    for (int k = 1; k < 8; k++) begin
      chk("fullrw_data", o_fifo_data, ent(4*k, 'h13+k));
      drive(1'b0, '0, 1'b1, 1'b0);
      step();
    end
    chk("fullrw_last", o_fifo_data, ent('h100, 'h99));
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("fullrw_empty", o_fifo_valid, 0);

    // Interleaved traffic across pointer wrap, tracked by a queue model.
    wi = 0;
    ri = 0;
    for (int cyc = 0; cyc < 400 && ri < 20; cyc++) begin
      if (q.size() > 0) begin
        chk("wrap_valid", o_fifo_valid, 1);
        chk("wrap_head",  o_fifo_data, q[0]);
      end else begin
        chk("wrap_empty", o_fifo_valid, 0);
      end
      chk("wrap_count", o_fifo_count, q.size());
      wr = (wi < 20) && ($urandom_range(0, 2) != 0);
      rd = ($urandom_range(0, 2) != 0);
      drive(wr, ent(4*wi, 'h13+wi), rd, 1'b0);
      rf = rd && (q.size() > 0);
      wf = wr && ((q.size() < 8) || rf);
      step();
      if (rf) begin
        void'(q.pop_front());
        ri++;
      end
      if (wf) begin
        q.push_back(ent(4*wi, 'h13+wi));
        wi++;
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("wrap_done", ri, 20);
    chk("wrap_final_count", o_fifo_count, 0);

    // Flush with five held, same-cycle read and write ignored.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, ent('h300+4*k, k), 1'b0, 1'b0);
      step();
    end
    chk("preflush_count", o_fifo_count, 5);
    drive(1'b1, ent('h500, 1), 1'b1, 1'b1);
    step();
    chk("flush_count", o_fifo_count, 0);
    chk("flush_valid", o_fifo_valid, 0);
    chk("flush_full",  o_fifo_full, 0);
    drive(1'b1, ent('h200, 'h13), 1'b0, 1'b0);
    step();
    chk("postflush_valid", o_fifo_valid, 1);
    chk("postflush_data",  o_fifo_data, ent('h200, 'h13));
    chk("postflush_count", o_fifo_count, 1);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
    chk("flush_empty_noop", o_fifo_count, 0);

    // Read while empty with concurrent write: no pop, no bypass.
    drive(1'b1, ent('h40, 'h13), 1'b1, 1'b0);
    #1;
    chk("nobypass_valid", o_fifo_valid, 0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("emptyrd_valid", o_fifo_valid, 1);
    chk("emptyrd_data",  o_fifo_data, ent('h40, 'h13));
    chk("emptyrd_count", o_fifo_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
